// File: rtl/ysyx_24070014_lsu_pkg.sv
// ysyx_24070014_lsu_pkg
//   Shared definitions for the load/store unit.
//   - RV32 funct3 size/sign encodings for loads and stores
//   - LSU control state enum

package ysyx_24070014_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/ysyx_24070014_lsu_align.sv
// ysyx_24070014_lsu_align
//   Combinational byte-lane logic for a 32-bit load/store unit.
//   Ports:
//     funct3    in   RV32 size/sign field
//     wen       in   1 = store (stores may not use the unsigned encodings)
//     addr_lo   in   low two address bits (byte offset in the word)
//     wdata     in   store data, value in the low bits
//     rdata     in   full aligned word returned by memory
//     wmask     out  byte-lane enables for the store
//     wdata_sh  out  store data replicated onto its byte lanes
//     rdata_ext out  selected byte/half/word, sign- or zero-extended
//     misalign  out  access crosses its natural alignment
//     illegal   out  funct3 not usable for this access direction

module ysyx_24070014_lsu_align
    import ysyx_24070014_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        wen,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Half select only looks at addr_lo[1]; a misaligned half never reaches memory.
    assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        wmask     = 4'b0000;
        wdata_sh  = wdata;
        rdata_ext = rdata;
        misalign  = 1'b0;
        illegal   = 1'b0;
        case (funct3)
            F3_B: begin
                wmask     = 4'b0001 << addr_lo;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = {{24{rd_byte[7]}}, rd_byte};
            end
            F3_H: begin
                wmask     = 4'b0011 << addr_lo;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = {{16{rd_half[15]}}, rd_half};
                misalign  = addr_lo[0];
            end
            F3_W: begin
                wmask     = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = rdata;
                misalign  = (addr_lo != 2'b00);
            end
            F3_BU: begin
                rdata_ext = {24'd0, rd_byte};
                illegal   = wen;
            end
            F3_HU: begin
                rdata_ext = {16'd0, rd_half};
                misalign  = addr_lo[0];
                illegal   = wen;
            end
            default: begin
                illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_24070014_lsu.sv
// ysyx_24070014_lsu
//   Load/store unit sitting after the ALU. Accepts one load or store per
//   request, issues it on a valid/ready memory port and returns the
//   extended load data (or an error) through a response handshake.
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     req_valid/req_ready          core request handshake (ready only in IDLE)
//     req_addr/wen/funct3/wdata    request fields, captured on acceptance
//     rsp_valid/rsp_ready          response handshake, held until consumed
//     rsp_rdata/rsp_err            writeback value (0 for stores/errors), error flag
//     mem_req_valid/mem_req_ready  memory request handshake
//     mem_addr/wen/wmask/wdata     word-aligned memory request fields
//     mem_rsp_valid/mem_rdata      memory response, one per accepted request
//   WORD_LEN must be 32.

module ysyx_24070014_lsu
    import ysyx_24070014_lsu_pkg::*;
#(
    parameter int WORD_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [WORD_LEN-1:0]   req_addr,
    input  logic                  req_wen,
    input  logic [2:0]            req_funct3,
    input  logic [WORD_LEN-1:0]   req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_LEN-1:0]   rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [WORD_LEN-1:0]   mem_addr,
    output logic                  mem_wen,
    output logic [WORD_LEN/8-1:0] mem_wmask,
    output logic [WORD_LEN-1:0]   mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [WORD_LEN-1:0]   mem_rdata
);

    lsu_state_e          state_q, state_d;
    logic [WORD_LEN-1:0] addr_q, addr_d;
    logic [WORD_LEN-1:0] wdata_q, wdata_d;
    logic [WORD_LEN-1:0] rdata_q, rdata_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                wen_q, wen_d;
    logic                err_q, err_d;

    logic                idle;
    logic [2:0]          al_funct3;
    logic                al_wen;
    logic [1:0]          al_addr_lo;
    logic [WORD_LEN-1:0] al_wdata;
    logic [3:0]          al_wmask;
    logic [WORD_LEN-1:0] al_wdata_sh;
    logic [WORD_LEN-1:0] al_rdata_ext;
    logic                al_misalign;
    logic                al_illegal;

    assign idle = (state_q == IDLE);

    // One align instance serves both phases: in IDLE it checks the incoming
    // request, afterwards it works from the captured fields.
    assign al_funct3  = idle ? req_funct3     : funct3_q;
    assign al_wen     = idle ? req_wen        : wen_q;
    assign al_addr_lo = idle ? req_addr[1:0]  : addr_q[1:0];
    assign al_wdata   = idle ? req_wdata      : wdata_q;

    ysyx_24070014_lsu_align u_align (
        .funct3    (al_funct3),
        .wen       (al_wen),
        .addr_lo   (al_addr_lo),
        .wdata     (al_wdata),
        .rdata     (mem_rdata),
        .wmask     (al_wmask),
        .wdata_sh  (al_wdata_sh),
        .rdata_ext (al_rdata_ext),
        .misalign  (al_misalign),
        .illegal   (al_illegal)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        funct3_d = funct3_q;
        wen_d    = wen_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    wen_d    = req_wen;
                    rdata_d  = '0;
                    if (al_misalign || al_illegal) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // A same-cycle mem_rsp_valid is not a response to this request.
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = wen_q ? '0 : al_rdata_ext;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= 3'b000;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            wen_q    <= wen_d;
            err_q    <= err_d;
        end
    end

    assign req_ready     = idle;
    assign rsp_valid     = (state_q == RESP);
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = {addr_q[WORD_LEN-1:2], 2'b00};
    assign mem_wen       = mem_req_valid & wen_q;
    assign mem_wmask     = mem_wen ? al_wmask : '0;
    assign mem_wdata     = al_wdata_sh;

endmodule

// File: tb/tb_ysyx_24070014_lsu.sv
// Scoreboard bench for ysyx_24070014_lsu: directed operations push expected
// memory requests and responses into queues; a memory model and a response
// monitor pop and compare whenever the DUT presents a handshake.

module tb_ysyx_24070014_lsu;
    import ysyx_24070014_lsu_pkg::*;

    typedef struct {
        logic        err;
        logic [31:0] rd;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  mask;
        logic [31:0] wd;
    } mreq_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    // memory model side / manual override side
    logic        m_ready, m_rsp, acc_pend;
    logic [31:0] m_rdata;
    logic        manual, o_ready, o_rsp;
    logic [31:0] mem_word;
    int          mem_stall_req, rsp_stall_req;
    int          mcnt, rcnt, mem_req_cycles;

    int total, bad;
    rsp_t  exp_rsp_q[$];
    mreq_t exp_mem_q[$];

    assign mem_req_ready = manual ? o_ready : m_ready;
    assign mem_rsp_valid = manual ? o_rsp   : m_rsp;
    assign mem_rdata     = m_rdata;

    ysyx_24070014_lsu #(.WORD_LEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wen       (req_wen),
        .req_funct3    (req_funct3),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wmask     (mem_wmask),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: stalls ready for mem_stall_req cycles, then answers the
    // cycle after acceptance.
    always @(negedge clk) begin
        m_rsp = 1'b0;
        if (manual || rst) begin
            m_ready  = 1'b0;
            acc_pend = 1'b0;
            mcnt     = 0;
        end else if (acc_pend) begin
            m_rsp    = 1'b1;
            m_rdata  = mem_word;
            m_ready  = 1'b0;
            acc_pend = 1'b0;
        end else if (mem_req_valid) begin
            mem_req_cycles++;
            chk("req_ready_busy_mem", 32'(req_ready), 32'd0);
            if (exp_mem_q.size() == 0) begin
                chk("mem_req_unexpected", 32'd1, 32'd0);
            end else begin
                chk("mem_addr", mem_addr, exp_mem_q[0].addr);
                chk("mem_wen", 32'(mem_wen), 32'(exp_mem_q[0].wen));
                chk("mem_wmask", 32'(mem_wmask), 32'(exp_mem_q[0].mask));
                if (exp_mem_q[0].wen) chk("mem_wdata", mem_wdata, exp_mem_q[0].wd);
            end
            if (mcnt < mem_stall_req) begin
                m_ready = 1'b0;
                mcnt++;
            end else begin
                m_ready  = 1'b1;
                acc_pend = 1'b1;
                mcnt     = 0;
                if (exp_mem_q.size() != 0) void'(exp_mem_q.pop_front());
            end
        end else begin
            m_ready = 1'b0;
        end
    end

    // Response monitor: checks every cycle rsp_valid is up, consumes after
    // rsp_stall_req cycles of backpressure.
    always @(negedge clk) begin
        if (rst) begin
            rsp_ready = 1'b1;
            rcnt      = 0;
        end else if (rsp_valid) begin
            chk("req_ready_busy_rsp", 32'(req_ready), 32'd0);
            if (exp_rsp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                chk("rsp_rdata", rsp_rdata, exp_rsp_q[0].rd);
                chk("rsp_err", 32'(rsp_err), 32'(exp_rsp_q[0].err));
                if (rcnt < rsp_stall_req) begin
                    rsp_ready = 1'b0;
                    rcnt++;
                end else begin
                    rsp_ready = 1'b1;
                    rcnt      = 0;
                    void'(exp_rsp_q.pop_front());
                end
            end
        end
    end

    task automatic do_op(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] word,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input logic [3:0] exp_mask, input logic [31:0] exp_wd,
                         input int mstall, input int rstall, input bit lat);
        int reqs_before;
        exp_rsp_q.push_back('{exp_err, exp_rd});
        if (!exp_err) exp_mem_q.push_back('{{addr[31:2], 2'b00}, wen, exp_mask, exp_wd});
        mem_word      = word;
        mem_stall_req = mstall;
        rsp_stall_req = rstall;
        @(negedge clk);
        reqs_before = mem_req_cycles;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        // later input changes must not affect the captured request
        req_valid  = 1'b0;
        req_wen    = ~wen;
        req_funct3 = 3'b111;
        req_addr   = ~addr;
        req_wdata  = ~wd;
        if (lat) begin
            @(negedge clk);
            if (exp_err) begin
                chk("err_lat_rsp_valid_c1", 32'(rsp_valid), 32'd1);
                chk("err_lat_rsp_err_c1", 32'(rsp_err), 32'd1);
            end else begin
                chk("lat_mem_req_valid_c1", 32'(mem_req_valid), 32'd1);
                @(negedge clk);
                chk("lat_rsp_valid_c2", 32'(rsp_valid), 32'd0);
                @(negedge clk);
                chk("lat_rsp_valid_c3", 32'(rsp_valid), 32'd1);
            end
        end
        for (int i = 0; i < 60 && exp_rsp_q.size() != 0; i++) @(negedge clk);
        chk("rsp_timeout", 32'(exp_rsp_q.size()), 32'd0);
        if (exp_err) chk("err_no_mem_req", 32'(mem_req_cycles - reqs_before), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0;
        manual = 1'b0; o_ready = 1'b0; o_rsp = 1'b0;
        m_ready = 1'b0; m_rsp = 1'b0; m_rdata = '0; acc_pend = 1'b0;
        mem_word = '0; mem_stall_req = 0; rsp_stall_req = 0;
        mcnt = 0; rcnt = 0; mem_req_cycles = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_wen", 32'(mem_wen), 32'd0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        rst = 1'b0;

        //    wen  f3     addr          wdata         mem word      exp rdata     err  mask     exp wdata     ms rs lat
        do_op(0, F3_W,  32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 4'b0000, 32'h0,        0, 0, 1);
        do_op(0, F3_B,  32'h8000_0007, 32'h0,        32'h80FF_0000, 32'hFFFF_FF80, 0, 4'b0000, 32'h0,        0, 0, 0);
        do_op(0, F3_BU, 32'h8000_0007, 32'h0,        32'h80FF_0000, 32'h0000_0080, 0, 4'b0000, 32'h0,        0, 0, 0);
        do_op(0, F3_HU, 32'h8000_0002, 32'h0,        32'h80FF_0000, 32'h0000_80FF, 0, 4'b0000, 32'h0,        0, 0, 0);
        do_op(0, F3_H,  32'h8000_0002, 32'h0,        32'h80FF_0000, 32'hFFFF_80FF, 0, 4'b0000, 32'h0,        0, 0, 0);
        do_op(0, F3_B,  32'h8000_0006, 32'h0,        32'h80FF_0000, 32'hFFFF_FFFF, 0, 4'b0000, 32'h0,        0, 0, 0);
        do_op(0, F3_H,  32'h8000_0000, 32'h0,        32'h1234_7FFE, 32'h0000_7FFE, 0, 4'b0000, 32'h0,        0, 0, 0);
        do_op(1, F3_B,  32'h8000_0003, 32'h1234_56AB, 32'h5555_5555, 32'h0,       0, 4'b1000, 32'hABAB_ABAB, 0, 0, 0);
        do_op(1, F3_B,  32'h8000_0001, 32'h0000_0042, 32'h0,        32'h0,        0, 4'b0010, 32'h4242_4242, 0, 0, 0);
        do_op(1, F3_H,  32'h8000_0002, 32'h0000_BEEF, 32'h0,        32'h0,        0, 4'b1100, 32'hBEEF_BEEF, 0, 0, 0);
        do_op(1, F3_W,  32'h8000_0008, 32'hCAFE_F00D, 32'h0,        32'h0,        0, 4'b1111, 32'hCAFE_F00D, 0, 0, 0);
        // error paths
        do_op(0, F3_H,  32'h8000_0001, 32'h0,        32'h0,        32'h0,        1, 4'b0000, 32'h0,        0, 0, 1);
        do_op(1, F3_W,  32'h8000_0002, 32'h1111_1111, 32'h0,       32'h0,        1, 4'b0000, 32'h0,        0, 0, 1);
        do_op(0, 3'b011, 32'h8000_0000, 32'h0,       32'h0,        32'h0,        1, 4'b0000, 32'h0,        0, 0, 0);
        do_op(1, F3_BU, 32'h8000_0000, 32'h0000_00FF, 32'h0,       32'h0,        1, 4'b0000, 32'h0,        0, 0, 0);
        do_op(0, 3'b110, 32'h8000_0000, 32'h0,       32'h0,        32'h0,        1, 4'b0000, 32'h0,        0, 0, 0);
        // backpressure: 3 cycles of mem_req_ready low, 2 cycles of rsp_ready low
        do_op(0, F3_W,  32'h8000_0010, 32'h0,        32'h0123_4567, 32'h0123_4567, 0, 4'b0000, 32'h0,       3, 2, 0);

        // reset while in WAIT, then a stale memory response
        manual = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = F3_W; req_addr = 32'h8000_0040;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_req_valid", 32'(mem_req_valid), 32'd1);
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        chk("rstmid_in_wait", 32'(mem_req_valid | req_ready | rsp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_req_ready", 32'(req_ready), 32'd1);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_mem_req_valid_after", 32'(mem_req_valid), 32'd0);
        o_rsp = 1'b1;
        @(negedge clk);
        o_rsp = 1'b0;
        chk("stale_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stale_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("stale_rsp_valid_2", 32'(rsp_valid), 32'd0);
        manual = 1'b0;
        do_op(0, F3_W,  32'h8000_0020, 32'h0,        32'hA5A5_5A5A, 32'hA5A5_5A5A, 0, 4'b0000, 32'h0,       0, 0, 1);

        repeat (3) @(negedge clk);
        chk("mem_queue_empty", 32'(exp_mem_q.size()), 32'd0);
        chk("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
